pipe_if_id_fetch_queue: RTL

//  Decoupling queue between the IF stage and the ID stage of the pipelined MIPS core.

---
 rtl/pipe_if_id_fetch_queue.sv | 92 +++++++++
 1 files changed

// File: rtl/pipe_if_id_fetch_queue.sv
// IF->ID decoupling queue: circular buffer of fetched instructions with their prediction tags.
// Show-ahead head drives the ID stage from registered storage; flush discards every entry.
module pipe_if_id_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_pc4,
  input  logic [31:0]   if_inst,
  input  logic          if_pre_taken,
  input  logic [31:0]   if_pre_bjpc,
  output logic          if_stall,
  input  logic          flush,
  input  logic          id_stall,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_pc4,
  output logic [31:0]   id_inst,
  output logic          id_pre_taken,
  output logic [31:0]   id_pre_bjpc,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        pre_taken;
    logic [31:0] pre_bjpc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = if_valid & ~full & ~flush;
  assign pop   = ~empty & ~id_stall & ~flush;

  // Control state: pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; outputs are gated by empty instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: if_pc, pc4: if_pc4, inst: if_inst,
                               pre_taken: if_pre_taken, pre_bjpc: if_pre_bjpc};
  end

  assign head         = mem[rd_ptr];
  assign if_stall     = full;
  assign id_valid     = ~empty;
  assign id_pc        = empty ? 32'h0 : head.pc;
  assign id_pc4       = empty ? 32'h0 : head.pc4;
  assign id_inst      = empty ? 32'h0 : head.inst;
  assign id_pre_taken = empty ? 1'b0  : head.pre_taken;
  assign id_pre_bjpc  = empty ? 32'h0 : head.pre_bjpc;
  assign count        = count_q;

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
  a_no_under:  assert property (@(posedge clk) disable iff (!rst_n) !(empty && pop));

endmodule
